// File: rtl/noc_arb_pkg.sv
// Shared types and helpers for the router output-port switch arbiter.
// Port index constants follow the router's local/N/E/S/W ordering.
package noc_arb_pkg;

  typedef enum logic [0:0] {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } arb_state_t;

  localparam int PORT_LOCAL = 0;
  localparam int PORT_N     = 1;
  localparam int PORT_E     = 2;
  localparam int PORT_S     = 3;
  localparam int PORT_W     = 4;

  // (base + off) mod n, valid for base < n and off < n; avoids a divider
  // when n is not a power of two.
  function automatic int wrap_idx(input int base, input int off, input int n);
    int s;
    s = base + off;
    if (s >= n) s = s - n;
    return s;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational rotate-then-find-first picker: first requester at or after
// ptr_i, wrapping to index 0. RR_MODE=0 searches from index 0 only.
module rr_pick
  import noc_arb_pkg::*;
#(
  parameter int N_PORTS = 5,
  parameter int IDX_W   = $clog2(N_PORTS),
  parameter bit RR_MODE = 1'b1
) (
  input  logic [N_PORTS-1:0] req_i,
  input  logic [IDX_W-1:0]   ptr_i,
  output logic [N_PORTS-1:0] win_o,
  output logic [IDX_W-1:0]   win_idx_o,
  output logic               any_o
);

  logic [IDX_W-1:0]   base;
  logic [N_PORTS-1:0] rot;
  int                 j;

  assign base  = RR_MODE ? ptr_i : '0;
  assign any_o = |req_i;

  always_comb begin
    rot       = '0;
    win_o     = '0;
    win_idx_o = '0;
    j         = 0;
    for (int k = 0; k < N_PORTS; k++) begin
      rot[k] = req_i[wrap_idx(int'(base), k, N_PORTS)];
    end
    // Walk downwards so the lowest rotated position overwrites last.
    for (int k = N_PORTS - 1; k >= 0; k--) begin
      if (rot[k]) begin
        j         = wrap_idx(int'(base), k, N_PORTS);
        win_idx_o = IDX_W'(j);
        win_o     = '0;
        win_o[j]  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/rr_port_arbiter.sv
// Per-output-port wormhole switch arbiter: grants one input for a whole
// packet (head to tail), then rotates priority past the served port.
module rr_port_arbiter
  import noc_arb_pkg::*;
#(
  parameter int N_PORTS      = 5,
  parameter int IDX_W        = $clog2(N_PORTS),
  parameter bit RR_MODE      = 1'b1,
  parameter int HOLD_TIMEOUT = 0,
  parameter int TO_W         = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [N_PORTS-1:0] req,
  input  logic [N_PORTS-1:0] tail,
  input  logic               out_ready,
  output logic [N_PORTS-1:0] grant,
  output logic               grant_valid,
  output logic [IDX_W-1:0]   grant_idx,
  output logic               fire,
  output arb_state_t         state_dbg,
  output logic [IDX_W-1:0]   ptr_dbg
);

  // Handshake: a flit moves on any cycle where the granted port requests
  // and out_ready is high (fire); neither side waits on the other's level.

  arb_state_t         state_q, state_d;
  logic [IDX_W-1:0]   ptr_q, ptr_d;
  logic [TO_W-1:0]    stall_q, stall_d;
  logic [N_PORTS-1:0] grant_q, grant_d;
  logic [IDX_W-1:0]   idx_q, idx_d;

  logic [N_PORTS-1:0] pick_win;
  logic [IDX_W-1:0]   pick_idx;
  logic               pick_any;
  logic               req_gnt;
  logic               release_c;

  rr_pick #(
    .N_PORTS (N_PORTS),
    .IDX_W   (IDX_W),
    .RR_MODE (RR_MODE)
  ) u_pick (
    .req_i     (req),
    .ptr_i     (ptr_q),
    .win_o     (pick_win),
    .win_idx_o (pick_idx),
    .any_o     (pick_any)
  );

  assign req_gnt     = req[idx_q];
  assign grant       = grant_q;
  assign grant_valid = |grant_q;
  assign grant_idx   = idx_q;
  assign fire        = grant_valid & req_gnt & out_ready;
  assign state_dbg   = state_q;
  assign ptr_dbg     = ptr_q;

  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    stall_d   = stall_q;
    grant_d   = grant_q;
    idx_d     = idx_q;
    release_c = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (pick_any) begin
          grant_d = pick_win;
          idx_d   = pick_idx;
          stall_d = '0;
          state_d = LOCKED;
        end
      end
      LOCKED: begin
        if (fire && tail[idx_q]) begin
          release_c = 1'b1;
        end else if (!req_gnt) begin
          // Upstream ran dry mid-packet; optionally give up the lock.
          if (HOLD_TIMEOUT != 0 && stall_q == TO_W'(HOLD_TIMEOUT - 1)) begin
            release_c = 1'b1;
          end else begin
            stall_d = stall_q + 1'b1;
          end
        end else begin
          stall_d = '0;
        end
        if (release_c) begin
          grant_d = '0;
          idx_d   = '0;
          stall_d = '0;
          state_d = IDLE;
          if (RR_MODE) begin
            ptr_d = (idx_q == IDX_W'(N_PORTS - 1)) ? '0 : idx_q + 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      stall_q <= '0;
      grant_q <= '0;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      stall_q <= stall_d;
      grant_q <= grant_d;
      idx_q   <= idx_d;
    end
  end

endmodule

// File: tb/tb_rr_port_arbiter.sv
// Directed bench for rr_port_arbiter: three instances (round-robin default,
// stall timeout of 4, fixed priority) share one stimulus stream.
module tb_rr_port_arbiter;
  import noc_arb_pkg::*;

  localparam int N = 5;
  localparam int W = 3;

  logic         clk;
  logic         rst;
  logic [N-1:0] req;
  logic [N-1:0] tail;
  logic         out_ready;

  logic [N-1:0] g_grant, t_grant, f_grant;
  logic         g_valid, t_valid, f_valid;
  logic [W-1:0] g_idx, t_idx, f_idx;
  logic         g_fire, t_fire, f_fire;
  arb_state_t   g_state, t_state, f_state;
  logic [W-1:0] g_ptr, t_ptr, f_ptr;

  int n_total;
  int n_bad;
  logic [W-1:0] exp_q[$];
  logic [W-1:0] exp_idx;

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  rr_port_arbiter #(.N_PORTS(N), .RR_MODE(1'b1), .HOLD_TIMEOUT(0)) u_dut (
    .clk(clk), .rst(rst), .req(req), .tail(tail), .out_ready(out_ready),
    .grant(g_grant), .grant_valid(g_valid), .grant_idx(g_idx), .fire(g_fire),
    .state_dbg(g_state), .ptr_dbg(g_ptr)
  );

  rr_port_arbiter #(.N_PORTS(N), .RR_MODE(1'b1), .HOLD_TIMEOUT(4)) u_to (
    .clk(clk), .rst(rst), .req(req), .tail(tail), .out_ready(out_ready),
    .grant(t_grant), .grant_valid(t_valid), .grant_idx(t_idx), .fire(t_fire),
    .state_dbg(t_state), .ptr_dbg(t_ptr)
  );

  rr_port_arbiter #(.N_PORTS(N), .RR_MODE(1'b0), .HOLD_TIMEOUT(0)) u_fp (
    .clk(clk), .rst(rst), .req(req), .tail(tail), .out_ready(out_ready),
    .grant(f_grant), .grant_valid(f_valid), .grant_idx(f_idx), .fire(f_fire),
    .state_dbg(f_state), .ptr_dbg(f_ptr)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  initial begin
    n_total   = 0;
    n_bad     = 0;
    rst       = 1'b1;
    req       = 5'b11111;
    tail      = 5'b00000;
    out_ready = 1'b1;

    // 1: held reset ignores requests
    for (int c = 0; c < 2; c++) begin
      tick();
      check("rst_grant", 32'(g_grant), 32'd0);
      check("rst_idx", 32'(g_idx), 32'd0);
      check("rst_valid", 32'(g_valid), 32'd0);
      check("rst_state", 32'(g_state), 32'(IDLE));
      check("rst_ptr", 32'(g_ptr), 32'd0);
    end
    rst = 1'b0;

    // 2: round-robin over single-flit packets, bubble between grants
    req  = 5'b10101;
    tail = 5'b11111;
    exp_q.push_back(3'd0);
    exp_q.push_back(3'd2);
    exp_q.push_back(3'd4);
    exp_q.push_back(3'd0);
    for (int c = 1; c <= 8; c++) begin
      tick();
      if (c % 2 == 1) begin
        exp_idx = exp_q.pop_front();
        check("rr_idx", 32'(g_idx), 32'(exp_idx));
        check("rr_grant", 32'(g_grant), 32'(5'b00001 << exp_idx));
        check("rr_fire", 32'(g_fire), 32'd1);
      end else begin
        check("rr_bubble", 32'(g_grant), 32'd0);
      end
    end
    check("rr_ptr_end", 32'(g_ptr), 32'd1);

    // 3: four-flit packet on port S with a 3-cycle downstream stall
    do_reset();
    req  = 5'b01000;
    tail = 5'b00000;
    tick();
    check("lk_grant", 32'(g_grant), 32'b01000);
    req = 5'b01010;
    #1;
    check("lk_fire_head", 32'(g_fire), 32'd1);
    tick();
    out_ready = 1'b0;
    #1;
    check("lk_fire_stall", 32'(g_fire), 32'd0);
    for (int c = 0; c < 3; c++) begin
      tick();
      check("lk_hold", 32'(g_grant), 32'b01000);
    end
    out_ready = 1'b1;
    tick();
    check("lk_body2", 32'(g_grant), 32'b01000);
    tick();
    check("lk_body3", 32'(g_grant), 32'b01000);
    tail = 5'b01000;
    #1;
    check("lk_fire_tail", 32'(g_fire), 32'd1);
    tick();
    check("lk_release", 32'(g_grant), 32'd0);
    check("lk_ptr", 32'(g_ptr), 32'(PORT_W));
    req  = 5'b00010;
    tail = 5'b00000;
    tick();
    check("lk_next_idx", 32'(g_idx), 32'(PORT_N));
    check("lk_next_grant", 32'(g_grant), 32'b00010);

    // 4: stall timeout on port E (only the HOLD_TIMEOUT=4 instance releases)
    do_reset();
    req = 5'b00100;
    tick();
    check("to_grant", 32'(t_grant), 32'b00100);
    req = 5'b00000;
    for (int c = 1; c <= 3; c++) begin
      tick();
      check("to_hold", 32'(t_grant), 32'b00100);
    end
    tick();
    check("to_clear", 32'(t_grant), 32'd0);
    check("to_state", 32'(t_state), 32'(IDLE));
    check("to_ptr", 32'(t_ptr), 32'(PORT_S));
    check("to_nolimit", 32'(g_grant), 32'b00100);

    // 5: fixed priority vs round-robin on the same stream
    do_reset();
    req  = 5'b11000;
    tail = 5'b00000;
    tick();
    check("fp_first", 32'(f_idx), 32'(PORT_S));
    req  = 5'b11001;
    tail = 5'b01000;
    tick();
    check("fp_release", 32'(f_grant), 32'd0);
    tail = 5'b00000;
    tick();
    check("fp_second", 32'(f_idx), 32'(PORT_LOCAL));
    check("fp_ptr_fixed", 32'(f_ptr), 32'd0);
    check("rr_second", 32'(g_idx), 32'(PORT_W));

    // 6: reset pulse in the middle of a packet on port W
    do_reset();
    req  = 5'b00010;
    tail = 5'b00010;
    tick();
    check("mr_pre_idx", 32'(g_idx), 32'(PORT_N));
    tick();
    req  = 5'b10000;
    tail = 5'b00000;
    tick();
    check("mr_lock", 32'(g_grant), 32'b10000);
    check("mr_ptr_pre", 32'(g_ptr), 32'd2);
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("mr_grant", 32'(g_grant), 32'd0);
    check("mr_ptr", 32'(g_ptr), 32'd0);
    check("mr_state", 32'(g_state), 32'(IDLE));
    check("mr_fire", 32'(g_fire), 32'd0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
